// File: rtl/regfile_cmd_ctrl_pkg.sv
// rtl/regfile_cmd_ctrl_pkg.sv - shared widths, opcodes and FSM encoding for the register file command front-end
package regfile_cmd_ctrl_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int BYTE_WIDTH = 8;

  localparam logic [7:0] WR_OPCODE = 8'hAA;
  localparam logic [7:0] RD_OPCODE = 8'hBB;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_ADDR = 4'd1,
    S_GET_DLO  = 4'd2,
    S_GET_DHI  = 4'd3,
    S_WR_ISSUE = 4'd4,
    S_RD_ISSUE = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_TX_LO    = 4'd7,
    S_TX_HI    = 4'd8
  } state_t;

  // States in which a command byte may be consumed from the receive side.
  function automatic logic rx_state(input state_t s);
    return (s == S_IDLE) || (s == S_GET_ADDR) || (s == S_GET_DLO) || (s == S_GET_DHI);
  endfunction

  function automatic logic tx_state(input state_t s);
    return (s == S_TX_LO) || (s == S_TX_HI);
  endfunction

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// rtl/regfile_cmd_ctrl.sv - parses write/read byte frames, strobes the register file, returns read data as two bytes
module regfile_cmd_ctrl
  import regfile_cmd_ctrl_pkg::*;
#(
  parameter int              DATA_WIDTH = regfile_cmd_ctrl_pkg::DATA_WIDTH,
  parameter int              ADDR_WIDTH = regfile_cmd_ctrl_pkg::ADDR_WIDTH,
  parameter int              BYTE_WIDTH = regfile_cmd_ctrl_pkg::BYTE_WIDTH,
  parameter logic [BYTE_WIDTH-1:0] WR_OPCODE = regfile_cmd_ctrl_pkg::WR_OPCODE,
  parameter logic [BYTE_WIDTH-1:0] RD_OPCODE = regfile_cmd_ctrl_pkg::RD_OPCODE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BYTE_WIDTH-1:0] RX_Data,
  input  logic                  RX_Valid,
  output logic                  RX_Ready,
  output logic [BYTE_WIDTH-1:0] TX_Data,
  output logic                  TX_Valid,
  input  logic                  TX_Ready,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  Busy
);

  state_t state, state_next;
  logic   is_read;
  logic   rx_fire, tx_fire;
  logic [BYTE_WIDTH-1:0] hold_hi;

  assign rx_fire = RX_Valid & RX_Ready;
  assign tx_fire = TX_Valid & TX_Ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (rx_fire && (RX_Data == WR_OPCODE || RX_Data == RD_OPCODE))
                    state_next = S_GET_ADDR;
      S_GET_ADDR: if (rx_fire) state_next = is_read ? S_RD_ISSUE : S_GET_DLO;
      S_GET_DLO:  if (rx_fire) state_next = S_GET_DHI;
      S_GET_DHI:  if (rx_fire) state_next = S_WR_ISSUE;
      S_WR_ISSUE: state_next = S_IDLE;
      S_RD_ISSUE: state_next = S_RD_WAIT;
      S_RD_WAIT:  state_next = S_TX_LO;
      S_TX_LO:    if (tx_fire) state_next = S_TX_HI;
      S_TX_HI:    if (tx_fire) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Status and strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RX_Ready <= 1'b0;
      TX_Valid <= 1'b0;
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      RX_Ready <= rx_state(state_next);
      TX_Valid <= tx_state(state_next);
      WrEn     <= (state_next == S_WR_ISSUE);
      RdEn     <= (state_next == S_RD_ISSUE);
      Busy     <= (state_next != S_IDLE);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      is_read <= 1'b0;
      Address <= '0;
      WrData  <= '0;
    end else if (rx_fire) begin
      case (state)
        S_IDLE:     is_read <= (RX_Data == RD_OPCODE);
        S_GET_ADDR: Address <= RX_Data[ADDR_WIDTH-1:0];
        S_GET_DLO:  WrData[BYTE_WIDTH-1:0] <= RX_Data;
        S_GET_DHI:  WrData[DATA_WIDTH-1:BYTE_WIDTH] <= RX_Data;
        default:    ;
      endcase
    end
  end

  // The low byte goes straight to TX_Data; only the high byte needs holding until its turn.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_Data <= '0;
      hold_hi <= '0;
    end else if (state == S_RD_WAIT) begin
      TX_Data <= RdData[BYTE_WIDTH-1:0];
      hold_hi <= RdData[DATA_WIDTH-1:BYTE_WIDTH];
    end else if (state == S_TX_LO && tx_fire) begin
      TX_Data <= hold_hi;
    end
  end

endmodule

// File: doc/regfile_cmd_ctrl.md
Name: regfile_cmd_ctrl

Overview:
Command front-end placed directly upstream of the 8x16 register file. It receives a byte stream from the serial/receive side with a valid/ready handshake and parses write and read command frames. It drives the register file's WrEn/RdEn/Address/WrData and captures RdData. Read results are returned as two bytes over a valid/ready transmit handshake.

Parameters:
DATA_WIDTH, 16, register file word width (fixed at 2 bytes: low byte, then high byte)
ADDR_WIDTH, 3, register file address width; selects 8 locations
BYTE_WIDTH, 8, width of the command/response byte stream
WR_OPCODE, 8'hAA, first byte of a write frame
RD_OPCODE, 8'hBB, first byte of a read frame

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
RX_Data  input  BYTE_WIDTH  incoming command byte
RX_Valid  input  1  RX_Data is valid
RX_Ready  output  1  block accepts a byte this cycle
TX_Data  output  BYTE_WIDTH  response byte
TX_Valid  output  1  TX_Data is valid
TX_Ready  input  1  downstream accepts TX_Data
WrEn  output  1  register file write strobe, one cycle
RdEn  output  1  register file read strobe, one cycle
Address  output  ADDR_WIDTH  register file address
WrData  output  DATA_WIDTH  register file write data
RdData  input  DATA_WIDTH  register file read data (registered inside the register file)
Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (RST low, async): FSM=IDLE; RX_Ready=0, TX_Valid=0, TX_Data=0, WrEn=0, RdEn=0, Address=0, WrData=0, Busy=0.
- All outputs are registered.
- Byte accepted only on a cycle with RX_Valid & RX_Ready. TX byte consumed only on TX_Valid & TX_Ready.
- RX_Ready=1 in IDLE, GET_ADDR, GET_DLO, GET_DHI; 0 in all other states.
- FSM states: IDLE, GET_ADDR, GET_DLO, GET_DHI, WR_ISSUE, RD_ISSUE, RD_WAIT, TX_LO, TX_HI.
- IDLE: a byte equal to WR_OPCODE or RD_OPCODE → GET_ADDR, with the opcode latched. Any other byte is dropped and the FSM stays in IDLE.
- GET_ADDR: Address <= byte[ADDR_WIDTH-1:0]; upper bits are ignored. Write → GET_DLO; read → RD_ISSUE.
- GET_DLO: WrData[7:0] <= byte → GET_DHI.
- GET_DHI: WrData[15:8] <= byte → WR_ISSUE.
- WR_ISSUE: WrEn=1 for exactly one cycle, RdEn=0 → IDLE.
- RD_ISSUE: RdEn=1 for exactly one cycle, WrEn=0 → RD_WAIT.
- RD_WAIT: one cycle. At the end of this cycle RdData is captured into a 16-bit holding register → TX_LO.
  - Read latency: RdData is sampled on the 2nd rising edge after the edge that raised RdEn.
- TX_LO: TX_Data=hold[7:0], TX_Valid=1. Hold both until TX_Ready; on handshake → TX_HI.
- TX_HI: TX_Data=hold[15:8], TX_Valid=1. On handshake TX_Valid drops → IDLE.
- WrEn and RdEn are never high in the same cycle. Address and WrData stay stable through the strobe cycle and keep their value afterwards.
- Bytes arriving while RX_Ready=0 are not consumed; the sender holds them.
- Back-to-back frames: the first opcode byte can be accepted the cycle after returning to IDLE.
- TX_Ready held low indefinitely: the FSM stalls in TX_LO/TX_HI with no timeout.
- RST asserted mid-frame or mid-response: immediate return to reset state. A partial frame is discarded; no strobe is issued.
- Busy is 1 in every state except IDLE.

Decomposition:
- Shared package holds:
  - the state enum/localparams (9 states, 4-bit encoding);
  - WR_OPCODE and RD_OPCODE constants;
  - DATA_WIDTH, ADDR_WIDTH and BYTE_WIDTH defaults, shared with the register file integration.
- No sub-module needed. A single FSM plus datapath registers is natural.

Test Plan:
- Reset: hold RST low 3 cycles with RX_Valid=1 → RX_Ready, TX_Valid, WrEn, RdEn, Busy all 0. After release, RX_Ready=1.
- Write: send AA,03,34,12 → exactly one WrEn pulse with Address=3, WrData=16'h1234, RdEn=0, then return to IDLE.
- Read-back: write AA,05,CD,AB; then send BB,05 → one RdEn pulse with Address=5, then TX bytes CD then AB. Also checks read latency and byte order.
- TX backpressure: during a read response hold TX_Ready=0 for 10 cycles → TX_Data=low byte stable and TX_Valid=1 throughout, RX_Ready=0. Releasing TX_Ready gives low byte, then high byte.
- Bad opcode and address truncation: send 55 → ignored, no strobe. Then AA,FF,01,00 → write to Address=7 with WrData=16'h0001.
- Mid-frame reset: send AA,02,11, then pulse RST low → no WrEn. The next frame AA,02,22,33 writes 16'h3322 to address 2 correctly.
